// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter: round-robin sharing of one spi_master among NREQ register-access clients
module spi_req_arbiter #(
  parameter int NREQ       = 4,
  parameter int START_HOLD = 10,
  parameter int GAP_CYC    = 16,
  parameter int TIMEOUT    = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_rw,
  input  logic [NREQ*8-1:0] req_addr,
  input  logic [NREQ*8-1:0] req_wdata,
  input  logic [9:0]        cfg_freq,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [9:0]        spi_freq,
  output logic              spi_start_w,
  output logic              spi_start_r,
  output logic [7:0]        spi_addr,
  output logic [7:0]        spi_wdata,
  input  logic [7:0]        spi_rdata,
  input  logic              spi_done
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef enum logic [2:0] {IDLE, START, WAIT, RESP, GAP} state_t;
  state_t          state, state_n;
  logic [IW-1:0]   last_gnt, last_gnt_n, own, own_n, pick;
  logic [IW:0]     s;
  logic [7:0]      cnt, cnt_n;
  logic [15:0]     tcnt, tcnt_n;
  logic            done_q, done_rise;
  logic [NREQ-1:0] gnt_n, ack_n;
  logic [7:0]      rdata_n, addr_n, wdata_n;
  logic [9:0]      freq_n;
  logic            err_n, sw_n, sr_n;
  assign done_rise = spi_done & ~done_q;
  assign busy = (state != IDLE);
  // Search starts just after the last owner; the lowest offset with a request wins.
  always_comb begin
    pick = '0;
    s = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      s = {1'b0, last_gnt} + (IW+1)'(k + 1);
      s = (s >= (IW+1)'(NREQ)) ? s - (IW+1)'(NREQ) : s;
      if (req[s[IW-1:0]]) pick = s[IW-1:0];
    end
  end
  always_comb begin
    state_n    = state;
    last_gnt_n = last_gnt;
    own_n      = own;
    cnt_n      = cnt;
    tcnt_n     = tcnt;
    gnt_n      = gnt;
    ack_n      = '0;
    rdata_n    = rsp_rdata;
    err_n      = rsp_err;
    freq_n     = spi_freq;
    sw_n       = spi_start_w;
    sr_n       = spi_start_r;
    addr_n     = spi_addr;
    wdata_n    = spi_wdata;
    case (state)
      IDLE: if (|req) begin
        state_n = START;
        own_n   = pick;
        gnt_n   = NREQ'(1) << pick;
        sr_n    = req_rw[pick];
        sw_n    = ~req_rw[pick];
        addr_n  = req_addr[8*pick +: 8];
        wdata_n = req_wdata[8*pick +: 8];
        freq_n  = cfg_freq;
        cnt_n   = '0;
      end
      START: if (cnt == 8'(START_HOLD - 1)) begin
        state_n = WAIT;
        sw_n    = 1'b0;
        sr_n    = 1'b0;
        tcnt_n  = '0;
      end else cnt_n = cnt + 8'd1;
      // A done edge on the expiry cycle still counts as a normal completion.
      WAIT: if (done_rise) begin
        state_n = RESP;
        ack_n   = gnt;
        rdata_n = spi_rdata;
        err_n   = 1'b0;
      end else if (tcnt == 16'(TIMEOUT - 1)) begin
        state_n = RESP;
        ack_n   = gnt;
        rdata_n = '0;
        err_n   = 1'b1;
      end else tcnt_n = tcnt + 16'd1;
      RESP: begin
        gnt_n      = '0;
        last_gnt_n = own;
        cnt_n      = '0;
        state_n    = (GAP_CYC == 0) ? IDLE : GAP;
      end
      GAP: if (cnt == 8'(GAP_CYC - 1)) state_n = IDLE;
      else cnt_n = cnt + 8'd1;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_gnt    <= IW'(NREQ - 1);
      own         <= '0;
      cnt         <= '0;
      tcnt        <= '0;
      done_q      <= 1'b0;
      gnt         <= '0;
      ack         <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      spi_freq    <= '0;
      spi_start_w <= 1'b0;
      spi_start_r <= 1'b0;
      spi_addr    <= '0;
      spi_wdata   <= '0;
    end else begin
      state       <= state_n;
      last_gnt    <= last_gnt_n;
      own         <= own_n;
      cnt         <= cnt_n;
      tcnt        <= tcnt_n;
      done_q      <= spi_done;
      gnt         <= gnt_n;
      ack         <= ack_n;
      rsp_rdata   <= rdata_n;
      rsp_err     <= err_n;
      spi_freq    <= freq_n;
      spi_start_w <= sw_n;
      spi_start_r <= sr_n;
      spi_addr    <= addr_n;
      spi_wdata   <= wdata_n;
    end
  end
endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb_spi_req_arbiter: directed checks of arbitration, strobe timing, timeout and reset abort
module tb_spi_req_arbiter;
  logic        clk, rst;
  logic [3:0]  req, req_rw, gnt, ack;
  logic [31:0] req_addr, req_wdata;
  logic [9:0]  cfg_freq, spi_freq;
  logic [7:0]  rsp_rdata, spi_addr, spi_wdata, spi_rdata;
  logic        rsp_err, busy, spi_start_w, spi_start_r, spi_done;
  int          total, bad;
  spi_req_arbiter #(.NREQ(4), .START_HOLD(10), .GAP_CYC(16), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .cfg_freq(cfg_freq), .gnt(gnt), .ack(ack),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .spi_freq(spi_freq),
    .spi_start_w(spi_start_w), .spi_start_r(spi_start_r), .spi_addr(spi_addr),
    .spi_wdata(spi_wdata), .spi_rdata(spi_rdata), .spi_done(spi_done)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      step;
      n++;
    end
    chk(tag, 64'(busy), 64'd0);
  endtask
  task automatic chk_zero(input string tag);
    chk(tag, 64'({gnt, ack, rsp_rdata, rsp_err, busy, spi_freq, spi_start_w,
                  spi_start_r, spi_addr, spi_wdata}), 64'd0);
  endtask
  initial begin
    int n, nhi;
    logic acc;
    logic [3:0] exp_g;
    total = 0; bad = 0;
    rst = 1'b1; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    cfg_freq = '0; spi_rdata = '0; spi_done = 1'b0;
    step;
    chk_zero("reset_outputs");
    rst = 1'b0;
    step;
    // 1: write from requester 0
    req_addr = 32'h0000_0055; req_wdata = 32'h0000_00AA; cfg_freq = 10'h123;
    req_rw = 4'b0000; req = 4'b0001;
    step;
    chk("t1_gnt", 64'(gnt), 64'h1);
    chk("t1_start_r", 64'(spi_start_r), 64'd0);
    chk("t1_freq", 64'(spi_freq), 64'h123);
    chk("t1_wdata", 64'(spi_wdata), 64'hAA);
    req_addr = 32'h0000_0066;
    nhi = 0;
    for (int i = 0; i < 10; i++) begin
      nhi += int'(spi_start_w);
      step;
    end
    chk("t1_strobe_cycles", 64'(nhi), 64'd10);
    chk("t1_strobe_drop", 64'(spi_start_w), 64'd0);
    chk("t1_addr_latched", 64'(spi_addr), 64'h55);
    repeat (3) step;
    spi_rdata = 8'h11; spi_done = 1'b1;
    step;
    chk("t1_ack", 64'(ack), 64'h1);
    chk("t1_err", 64'(rsp_err), 64'd0);
    spi_done = 1'b0; req = '0;
    step;
    chk("t1_ack_pulse", 64'({gnt, ack}), 64'd0);
    n = 0;
    while (busy && n < 100) begin
      step;
      n++;
    end
    chk("t1_gap_len", 64'(n), 64'd16);
    // 2: read from requester 2
    req_rw = 4'b0100; req = 4'b0100;
    step;
    chk("t2_gnt", 64'(gnt), 64'h4);
    chk("t2_strobes", 64'({spi_start_r, spi_start_w}), 64'b10);
    repeat (12) step;
    spi_rdata = 8'h3C; spi_done = 1'b1;
    step;
    chk("t2_ack", 64'(ack), 64'h4);
    chk("t2_rdata", 64'(rsp_rdata), 64'h3C);
    chk("t2_err", 64'(rsp_err), 64'd0);
    spi_done = 1'b0; req = '0;
    step;
    wait_idle("t2_idle");
    // 3: all requesters held, round robin from 0 after reset
    rst = 1'b1;
    #1;
    chk_zero("t3_reset");
    step;
    rst = 1'b0;
    step;
    req_rw = 4'b0000; req = 4'b1111;
    for (int t = 0; t < 6; t++) begin
      exp_g = 4'b0001 << (t % 4);
      n = 0;
      while (gnt == '0 && n < 64) begin
        step;
        n++;
      end
      chk($sformatf("t3_gnt%0d", t), 64'(gnt), 64'(exp_g));
      if (t > 0) chk($sformatf("t3_gap%0d", t), 64'(n), 64'd17);
      repeat (12) step;
      chk($sformatf("t3_onehot%0d", t), 64'($countones(gnt)), 64'd1);
      spi_rdata = 8'(t); spi_done = 1'b1;
      step;
      chk($sformatf("t3_ack%0d", t), 64'(ack), 64'(exp_g));
      spi_done = 1'b0;
      step;
      chk($sformatf("t3_drop%0d", t), 64'(gnt), 64'd0);
    end
    req = '0;
    wait_idle("t3_idle");
    // 4: timeout with done stuck low
    spi_rdata = 8'hEE; req = 4'b0001;
    step;
    chk("t4_gnt", 64'(gnt), 64'h1);
    acc = 1'b0;
    for (int i = 0; i < 73; i++) begin
      step;
      acc |= |ack;
    end
    chk("t4_no_early_ack", 64'(acc), 64'd0);
    step;
    chk("t4_ack", 64'(ack), 64'h1);
    chk("t4_err", 64'(rsp_err), 64'd1);
    chk("t4_rdata", 64'(rsp_rdata), 64'd0);
    req = '0;
    step;
    wait_idle("t4_idle");
    req_rw = 4'b0100; req = 4'b0100;
    step;
    chk("t4b_gnt", 64'(gnt), 64'h4);
    repeat (12) step;
    spi_rdata = 8'h77; spi_done = 1'b1;
    step;
    chk("t4b_resp", 64'({ack, rsp_err, rsp_rdata}), 64'({4'h4, 1'b0, 8'h77}));
    spi_done = 1'b0; req = '0;
    step;
    wait_idle("t4b_idle");
    // 6: requester drops req in START; done rises on the expiry cycle
    req_rw = 4'b1000; req = 4'b1000;
    step;
    chk("t6_gnt", 64'(gnt), 64'h8);
    step;
    step;
    req = '0;
    acc = 1'b0;
    for (int i = 0; i < 71; i++) begin
      step;
      acc |= |ack;
    end
    chk("t6_no_early_ack", 64'(acc), 64'd0);
    spi_rdata = 8'h5A; spi_done = 1'b1;
    step;
    chk("t6_resp", 64'({ack, rsp_err, rsp_rdata}), 64'({4'h8, 1'b0, 8'h5A}));
    spi_done = 1'b0;
    step;
    wait_idle("t6_idle");
    // 5: move pointer to 1, then reset during WAIT with req=0110
    req_rw = 4'b0000; req = 4'b0010;
    step;
    chk("t5a_gnt", 64'(gnt), 64'h2);
    repeat (12) step;
    spi_done = 1'b1;
    step;
    chk("t5a_ack", 64'(ack), 64'h2);
    spi_done = 1'b0; req = '0;
    step;
    wait_idle("t5a_idle");
    req = 4'b0110;
    step;
    chk("t5_gnt_before", 64'(gnt), 64'h4);
    repeat (15) step;
    chk("t5_busy_wait", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk_zero("t5_async_reset");
    spi_done = 1'b1;
    step;
    step;
    chk("t5_no_ack", 64'(ack), 64'd0);
    spi_done = 1'b0;
    rst = 1'b0;
    step;
    chk("t5_gnt_after", 64'(gnt), 64'h2);
    req = '0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
